game_ctl: RTL and testbench
===========================

GAME_CTL -- requirements
Module: game_ctl

Interface
REQ-001 SHALL have parameter SCREEN_W, default 1024, visible width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 768, visible height in pixels.
REQ-003 SHALL have parameter BALL_SIZE, default 16, ball square side in pixels.
REQ-004 SHALL have parameter PADDLE_W, default 128, paddle width in pixels.
REQ-005 SHALL have parameter PADDLE_Y, default 700, paddle top row.
REQ-006 SHALL have parameter SPEED, default 4, pixels moved per axis per frame.
REQ-007 SHALL have parameter LIVES, default 3, lives per game (1..3).
REQ-008 SHALL have port pclk  input  1  pixel clock; the only clock.
REQ-009 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-010 SHALL have port vblnk  input  1  vertical blank from the timing chain; its rising edge is the frame tick.
REQ-011 SHALL have port mouse_left  input  1  serve/restart button, level.
REQ-012 SHALL have port paddle_x  input  12  paddle left edge.
REQ-013 SHALL have port brick_hit  input  1  brick collision from the collision detector, any-width pulse.
REQ-014 SHALL have port ball_x  output  12  ball left edge, registered.
REQ-015 SHALL have port ball_y  output  12  ball top edge, registered.
REQ-016 SHALL have port state  output  2  00 SERVE, 01 PLAY, 10 OVER.
REQ-017 SHALL have port lives  output  2  remaining lives, registered.
REQ-018 SHALL have port game_over  output  1  high exactly while state is OVER.

Function
REQ-019 SHALL register vblnk and mouse_left; tick = vblnk & ~vblnk_q; press = mouse_left & ~mouse_left_q.
REQ-020 SHALL clamp paddle_x to SCREEN_W-PADDLE_W (896) before any use.
REQ-021 In SERVE, SHALL set each cycle ball_x = pc+PADDLE_W/2-BALL_SIZE/2, ball_y = PADDLE_Y-BALL_SIZE (684), pc = clamped paddle_x; 1-cycle latency.
REQ-022 SERVE SHALL go to PLAY on press, with dx=+1, dy=-1.
REQ-023 In PLAY, position SHALL change only on the edge where tick=1; other cycles hold.
REQ-024 X per tick: dx=+1 and x+SPEED >= SCREEN_W-BALL_SIZE (1008) -> x=1008, dx=-1; dx=-1 and x <= SPEED -> x=0, dx=+1; else x += dx*SPEED.
REQ-025 Y per tick, first match wins: (a) dy=-1 and y <= SPEED -> y=0, dy=+1; (b) paddle: dy=+1, y <= 684, y+SPEED >= 684, x+BALL_SIZE > pc, x < pc+PADDLE_W -> y=684, dy=-1; (c) miss: dy=+1 and y+SPEED >= SCREEN_H-BALL_SIZE (752); (d) else y += dy*SPEED.
REQ-026 brick_hit SHALL set a sticky flag; at tick in PLAY the flag inverts dy with normal step, unless (a), (b) or (c) applies that tick (then ignored); flag clears on every tick and outside PLAY.
REQ-027 Miss SHALL decrement lives; result 0 -> OVER, else -> SERVE; ball position frozen that tick.
REQ-028 OVER SHALL freeze ball_x/ball_y and assert game_over; press -> lives=LIVES, SERVE.
REQ-029 press in PLAY SHALL be ignored; press and tick on the same edge in SERVE -> PLAY only, no motion that edge.
REQ-030 All arithmetic SHALL be 12-bit unsigned with no wrap-around; underflow prevented by REQ-024/025 clamps.

Reset
REQ-031 reset=0 SHALL immediately force: state SERVE, lives=LIVES, ball_x=56, ball_y=684, dx=+1, dy=-1, game_over=0, all edge registers and brick flag 0.
REQ-032 Reset asserted mid-PLAY SHALL abandon motion with no life lost; after release the block behaves as from power-up.

Verification
REQ-033 Reset, paddle_x=200 -> next edge ball_x=256, ball_y=684, lives=3, state=00; paddle_x=1000 -> ball_x=952.
REQ-034 From SERVE at paddle_x=200, press then 3 ticks -> state=01, ball_x=268, ball_y=672.
REQ-035 PLAY, x=1004, dx=+1, tick -> x=1008, dx=-1; next tick -> x=1004; y=4, dy=-1 -> y=0, dy=+1.
REQ-036 dy=+1, y=680, pc=x-10 -> y=684, dy=-1; pc=x+200 -> descends to y=748, next tick lives 3->2, state SERVE.
REQ-037 Third miss -> state=10, game_over=1, ball frozen over 5 ticks; press -> lives=3, state=00.
REQ-038 brick_hit with y=4, dy=-1 same frame -> y=0, dy=+1 (single reflection); reset pulse mid-PLAY -> REQ-031 values.

Source files
------------

// File: rtl/game_ctl_if.sv
// game_ctl_if: player inputs, timing strobe and ball/score outputs of the game controller.
interface game_ctl_if;
   logic        vblnk;
   logic        mouse_left;
   logic        brick_hit;
   logic [11:0] paddle_x;
   logic [11:0] ball_x;
   logic [11:0] ball_y;
   logic [1:0]  state;
   logic [1:0]  lives;
   logic        game_over;
   modport master (output vblnk, mouse_left, brick_hit, paddle_x,
                   input ball_x, ball_y, state, lives, game_over);
   modport slave  (input vblnk, mouse_left, brick_hit, paddle_x,
                   output ball_x, ball_y, state, lives, game_over);
endinterface

// File: rtl/game_ctl.sv
// game_ctl: breakout ball/lives state machine; the ball moves once per vblank rising edge.
module game_ctl #(
   parameter int SCREEN_W  = 1024,
   parameter int SCREEN_H  = 768,
   parameter int BALL_SIZE = 16,
   parameter int PADDLE_W  = 128,
   parameter int PADDLE_Y  = 700,
   parameter int SPEED     = 4,
   parameter int LIVES     = 3
) (
   input logic       pclk,
   input logic       reset,
   game_ctl_if.slave io
);
   typedef enum logic [1:0] {SERVE = 2'b00, PLAY = 2'b01, OVER = 2'b10} state_t;
   localparam logic [11:0] X_MAX  = 12'(SCREEN_W - BALL_SIZE);
   localparam logic [11:0] Y_PAD  = 12'(PADDLE_Y - BALL_SIZE);
   localparam logic [11:0] Y_MISS = 12'(SCREEN_H - BALL_SIZE);
   localparam logic [11:0] PC_MAX = 12'(SCREEN_W - PADDLE_W);
   localparam logic [11:0] OFS    = 12'(PADDLE_W / 2 - BALL_SIZE / 2);
   localparam logic [11:0] STEP   = 12'(SPEED);
   localparam logic [11:0] BS     = 12'(BALL_SIZE);
   localparam logic [11:0] PW     = 12'(PADDLE_W);
   localparam logic [1:0]  LIV    = 2'(LIVES);
   state_t      st, st_n;
   logic [11:0] x, y, x_n, y_n, pc;
   logic [1:0]  lv, lv_n;
   logic        dx_r, dy_dn, dx_n, dy_n;
   logic        vb_q, ml_q, brick, brick_n;
   logic        tick, press, top, pad, miss, flip;
   always_comb begin
      pc = io.paddle_x > PC_MAX ? PC_MAX : io.paddle_x;
      tick = io.vblnk & ~vb_q;
      press = io.mouse_left & ~ml_q;
      top = !dy_dn && y <= STEP;
      pad = dy_dn && y <= Y_PAD && y + STEP >= Y_PAD && x + BS > pc && x < pc + PW;
      miss = dy_dn && !pad && y + STEP >= Y_MISS;
      flip = brick | io.brick_hit;
      st_n = st;
      x_n = x;
      y_n = y;
      lv_n = lv;
      dx_n = dx_r;
      dy_n = dy_dn;
      brick_n = st == PLAY && !tick && flip;
      if (st == SERVE) begin
         x_n = pc + OFS;
         y_n = Y_PAD;
         st_n = press ? PLAY : SERVE;
         dx_n = press ? 1'b1 : dx_r;
         dy_n = press ? 1'b0 : dy_dn;
      end else if (st == PLAY && tick && miss) begin
         lv_n = lv - 2'd1;
         st_n = lv == 2'd1 ? OVER : SERVE;
      end else if (st == PLAY && tick) begin
         if (dx_r && x + STEP >= X_MAX) begin
            x_n = X_MAX;
            dx_n = 1'b0;
         end else if (!dx_r && x <= STEP) begin
            x_n = '0;
            dx_n = 1'b1;
         end else
            x_n = dx_r ? x + STEP : x - STEP;
         // a pending brick hit only reverses a plain step, never a wall or paddle bounce
         if (top) begin
            y_n = '0;
            dy_n = 1'b1;
         end else if (pad) begin
            y_n = Y_PAD;
            dy_n = 1'b0;
         end else begin
            y_n = dy_dn ? y + STEP : y - STEP;
            dy_n = dy_dn ^ flip;
         end
      end else if (st == OVER && press) begin
         lv_n = LIV;
         st_n = SERVE;
      end
   end
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         st <= SERVE;
         lv <= LIV;
         x <= OFS;
         y <= Y_PAD;
         dx_r <= 1'b1;
         dy_dn <= 1'b0;
         vb_q <= 1'b0;
         ml_q <= 1'b0;
         brick <= 1'b0;
      end else begin
         st <= st_n;
         lv <= lv_n;
         x <= x_n;
         y <= y_n;
         dx_r <= dx_n;
         dy_dn <= dy_n;
         vb_q <= io.vblnk;
         ml_q <= io.mouse_left;
         brick <= brick_n;
      end
   end
   assign io.ball_x = x;
   assign io.ball_y = y;
   assign io.state = st;
   assign io.lives = lv;
   assign io.game_over = st == OVER;
endmodule

// File: tb/tb_game_ctl.sv
// tb_game_ctl: directed game scenarios; expected ball/state snapshots go to a queue checked on negedge.
module tb_game_ctl;
  logic pclk = 1'b0;
  logic reset = 1'b0;
  always #5 pclk = ~pclk;
  game_ctl_if bus();
  game_ctl dut (.pclk(pclk), .reset(reset), .io(bus.slave));
  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [1:0]  st;
    logic [1:0]  lv;
    logic        go;
  } snap_t;
  snap_t exp_q[$];
  string name_q[$];
  snap_t e, g;
  string nm;
  int n_chk = 0;
  int n_fail = 0;
  always @(negedge pclk) begin
    if (bus.game_over !== (bus.state == 2'b10)) begin
      n_fail++;
      $display("FAIL game_over=%0d while state=%0d", bus.game_over, bus.state);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      g = {bus.ball_x, bus.ball_y, bus.state, bus.lives, bus.game_over};
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL %s: got x=%0d y=%0d state=%0d lives=%0d go=%0d, expected x=%0d y=%0d state=%0d lives=%0d go=%0d",
                 nm, g.x, g.y, g.st, g.lv, g.go, e.x, e.y, e.st, e.lv, e.go);
      end
    end
  end
  task automatic expect_snap(input string n, input int x, input int y, input int st, input int lv, input int go);
    name_q.push_back(n);
    exp_q.push_back({12'(x), 12'(y), 2'(st), 2'(lv), 1'(go)});
  endtask
  task automatic step(input logic v, input logic m, input logic b);
    @(negedge pclk);
    bus.vblnk = v;
    bus.mouse_left = m;
    bus.brick_hit = b;
    @(posedge pclk);
    #1;
  endtask
  task automatic tick_n(input int n);
    repeat (n) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
  endtask
  task automatic tick_chk(input string n, input int x, input int y, input int st, input int lv, input int go);
    step(1'b1, 1'b0, 1'b0);
    expect_snap(n, x, y, st, lv, go);
    step(1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end
  initial begin
    bus.vblnk = 1'b0;
    bus.mouse_left = 1'b0;
    bus.brick_hit = 1'b0;
    bus.paddle_x = 12'd200;
    repeat (2) @(posedge pclk);
    #1;
    expect_snap("reset", 56, 684, 0, 3, 0);
    @(negedge pclk);
    #1 reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    expect_snap("serve_pc200", 256, 684, 0, 3, 0);
    bus.paddle_x = 12'd1000;
    step(1'b0, 1'b0, 1'b0);
    expect_snap("serve_clamp", 952, 684, 0, 3, 0);
    bus.paddle_x = 12'd200;
    step(1'b0, 1'b0, 1'b0);
    expect_snap("serve_back", 256, 684, 0, 3, 0);
    step(1'b0, 1'b1, 1'b0);
    expect_snap("press", 256, 684, 1, 3, 0);
    step(1'b0, 1'b0, 1'b0);
    tick_n(2);
    tick_chk("tick3", 268, 672, 1, 3, 0);
    tick_n(166);
    tick_chk("tick170", 936, 4, 1, 3, 0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    tick_chk("brick_at_top", 940, 0, 1, 3, 0);
    tick_chk("tick172", 944, 4, 1, 3, 0);
    tick_chk("tick173", 948, 8, 1, 3, 0);
    tick_n(13);
    tick_chk("right_near", 1004, 64, 1, 3, 0);
    tick_chk("right_clamp", 1008, 68, 1, 3, 0);
    tick_chk("right_back", 1004, 72, 1, 3, 0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    tick_chk("brick_mid", 1000, 76, 1, 3, 0);
    tick_chk("brick_rise", 996, 72, 1, 3, 0);
    step(1'b0, 1'b1, 1'b0);
    expect_snap("press_in_play", 996, 72, 1, 3, 0);
    step(1'b0, 1'b0, 1'b0);
    @(negedge pclk);
    reset = 1'b0;
    #2;
    expect_snap("reset_mid_play", 56, 684, 0, 3, 0);
    @(negedge pclk);
    #1 reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    expect_snap("after_reset", 256, 684, 0, 3, 0);
    step(1'b0, 1'b1, 1'b0);
    expect_snap("press_b", 256, 684, 1, 3, 0);
    step(1'b0, 1'b0, 1'b0);
    tick_n(340);
    tick_chk("tick341", 396, 680, 1, 3, 0);
    bus.paddle_x = 12'd386;
    tick_chk("paddle_hit", 392, 684, 1, 3, 0);
    tick_chk("paddle_rise", 388, 680, 1, 3, 0);
    bus.paddle_x = 12'd0;
    tick_n(356);
    tick_chk("tick700", 976, 748, 1, 3, 0);
    tick_chk("miss1", 976, 748, 0, 2, 0);
    step(1'b0, 1'b0, 1'b0);
    expect_snap("serve2", 56, 684, 0, 2, 0);
    step(1'b1, 1'b1, 1'b0);
    expect_snap("press_with_tick", 56, 684, 1, 2, 0);
    step(1'b0, 1'b0, 1'b0);
    tick_n(357);
    tick_chk("serve2_t358", 528, 748, 1, 2, 0);
    tick_chk("miss2", 528, 748, 0, 1, 0);
    step(1'b0, 1'b1, 1'b0);
    expect_snap("press3", 56, 684, 1, 1, 0);
    step(1'b0, 1'b0, 1'b0);
    tick_n(357);
    tick_chk("serve3_t358", 528, 748, 1, 1, 0);
    tick_chk("miss3_over", 528, 748, 2, 0, 1);
    for (int i = 0; i < 5; i++) tick_chk("over_frozen", 528, 748, 2, 0, 1);
    step(1'b0, 1'b1, 1'b0);
    expect_snap("restart", 528, 748, 0, 3, 0);
    step(1'b0, 1'b0, 1'b0);
    expect_snap("restart_serve", 56, 684, 0, 3, 0);
    repeat (3) @(negedge pclk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %0d expectations never compared", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    if (n_fail != 0) $fatal(1);
    $finish;
  end
endmodule
